// File: rtl/semaforo_scheduler_if.sv
// ----------------------------------------------------------------------------
// semaforo_scheduler_if
//   Signal bundle between the intersection phase scheduler and its neighbours
//   (sensors in, lamp heads / buzzer / animation logic out).
//
//   NOCHE         night request from the photoresistor (asynchronous)
//   BOTON_NS      NS pedestrian push-button (asynchronous)
//   SEMAFORO_EO   EO lamp head {G,Y,R}
//   SEMAFORO_NS   NS lamp head {G,Y,R}
//   PASO_NS       pedestrian walk permitted
//   VELOCIDAD_NS  buzzer/animation speed code (00 off .. 11 fast)
//   FASE          current phase code
//   TICK          one-clock pulse per scheduler tick
//
//   master: the environment (drives sensors, observes lamps)
//   slave : the scheduler
// ----------------------------------------------------------------------------
interface semaforo_scheduler_if;
    logic       NOCHE;
    logic       BOTON_NS;
    logic [2:0] SEMAFORO_EO;
    logic [2:0] SEMAFORO_NS;
    logic       PASO_NS;
    logic [1:0] VELOCIDAD_NS;
    logic [3:0] FASE;
    logic       TICK;

    modport master (
        output NOCHE, BOTON_NS,
        input  SEMAFORO_EO, SEMAFORO_NS, PASO_NS, VELOCIDAD_NS, FASE, TICK
    );

    modport slave (
        input  NOCHE, BOTON_NS,
        output SEMAFORO_EO, SEMAFORO_NS, PASO_NS, VELOCIDAD_NS, FASE, TICK
    );
endinterface

// File: rtl/semaforo_scheduler.sv
// ----------------------------------------------------------------------------
// semaforo_scheduler
//   Phase scheduler for a two-road (EO / NS) intersection with an NS
//   pedestrian crossing and a night flashing mode. A prescaler derives the
//   scheduler tick from CLK; the phase ring and its timer advance only on
//   ticks. All outputs are registered decodes of phase and timer.
//
//   CLK    system clock
//   RST_N  asynchronous active-low reset
//   bus    semaforo_scheduler_if.slave (sensors in, lamps/codes out)
// ----------------------------------------------------------------------------
module semaforo_scheduler #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int T_VERDE     = 8,
    parameter int T_PARPADEO  = 4,
    parameter int T_AMARILLO  = 3,
    parameter int T_ROJO      = 1,
    parameter int T_MIN_VERDE = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    semaforo_scheduler_if.slave   bus
);

    typedef enum logic [3:0] {
        EO_VERDE    = 4'd0,
        EO_PARPADEO = 4'd1,
        EO_AMARILLO = 4'd2,
        ROJO_1      = 4'd3,
        NS_VERDE    = 4'd4,
        NS_PARPADEO = 4'd5,
        NS_AMARILLO = 4'd6,
        ROJO_2      = 4'd7,
        NOCHE_PARP  = 4'd8
    } fase_t;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] LAMP_G   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_R   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // ------------------------------------------------------------------
    // Tick prescaler. tick_reg is high in exactly the cycle where the
    // prescaler holds TICK_DIV-1, so it is registered yet cycle-aligned.
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_reg, presc_next;
    logic          tick_reg;

    always_comb begin
        presc_next = presc_reg + 1'b1;
        if (presc_reg == PW'(TICK_DIV - 1))
            presc_next = '0;
    end

    // ------------------------------------------------------------------
    // Input synchronisers and button rising-edge detector.
    // ------------------------------------------------------------------
    logic [1:0] noche_sync_reg;
    logic [1:0] boton_sync_reg;
    logic       boton_prev_reg;
    logic       noche_s;
    logic       boton_edge;

    assign noche_s    = noche_sync_reg[1];
    assign boton_edge = boton_sync_reg[1] & ~boton_prev_reg;

    // ------------------------------------------------------------------
    // Phase state, tick timer and pedestrian call.
    // ------------------------------------------------------------------
    fase_t      state_reg, state_next;
    logic [4:0] tmr_reg, tmr_next;
    logic       pend_reg, pend_next;

    function automatic logic [4:0] dur(input fase_t s);
        case (s)
            EO_VERDE, NS_VERDE:       return 5'(T_VERDE);
            EO_PARPADEO, NS_PARPADEO: return 5'(T_PARPADEO);
            EO_AMARILLO, NS_AMARILLO: return 5'(T_AMARILLO);
            default:                  return 5'(T_ROJO);
        endcase
    endfunction

    function automatic fase_t ring_next(input fase_t s);
        case (s)
            EO_VERDE:    return EO_PARPADEO;
            EO_PARPADEO: return EO_AMARILLO;
            EO_AMARILLO: return ROJO_1;
            ROJO_1:      return NS_VERDE;
            NS_VERDE:    return NS_PARPADEO;
            NS_PARPADEO: return NS_AMARILLO;
            NS_AMARILLO: return ROJO_2;
            default:     return EO_VERDE;
        endcase
    endfunction

    always_comb begin
        state_next = state_reg;
        tmr_next   = tmr_reg;
        pend_next  = pend_reg;

        // A call is only meaningful while the walk signal is not already on.
        if (boton_edge && !(state_reg inside {EO_VERDE, EO_PARPADEO, NOCHE_PARP}))
            pend_next = 1'b1;

        case (state_reg)
            EO_VERDE, EO_PARPADEO, EO_AMARILLO, ROJO_1,
            NS_VERDE, NS_PARPADEO, NS_AMARILLO, ROJO_2: begin
                if (tick_reg) begin
                    if (state_reg == NS_VERDE && pend_reg &&
                        tmr_reg >= 5'(T_MIN_VERDE - 1)) begin
                        // Pedestrian waiting and minimum green served.
                        state_next = NS_PARPADEO;
                        tmr_next   = 5'd0;
                    end else if (tmr_reg == dur(state_reg) - 5'd1) begin
                        // Night is only entered from an all-red clearance.
                        if ((state_reg == ROJO_1 || state_reg == ROJO_2) && noche_s)
                            state_next = NOCHE_PARP;
                        else
                            state_next = ring_next(state_reg);
                        tmr_next = 5'd0;
                    end else begin
                        tmr_next = tmr_reg + 5'd1;
                    end
                end
            end
            NOCHE_PARP: begin
                if (tick_reg) begin
                    if (!noche_s) begin
                        state_next = ROJO_2;
                        tmr_next   = 5'd0;
                    end else begin
                        tmr_next = tmr_reg + 5'd1;   // free-runs, wraps 31->0
                    end
                end
            end
            default: begin
                state_next = ROJO_2;
                tmr_next   = 5'd0;
            end
        endcase

        // Entering EO green serves the call (and overrides a same-cycle
        // edge); night mode discards any call.
        if (state_next == NOCHE_PARP ||
            (state_next == EO_VERDE && state_reg != EO_VERDE))
            pend_next = 1'b0;
    end

    // ------------------------------------------------------------------
    // Output decode (registered one cycle behind state/timer).
    // ------------------------------------------------------------------
    logic [2:0] sem_eo_reg, sem_eo_next;
    logic [2:0] sem_ns_reg, sem_ns_next;
    logic       paso_reg, paso_next;
    logic [1:0] vel_reg, vel_next;
    logic [3:0] fase_reg;

    always_comb begin
        sem_eo_next = LAMP_R;
        sem_ns_next = LAMP_R;
        paso_next   = 1'b0;
        vel_next    = 2'b00;
        case (state_reg)
            EO_VERDE: begin
                sem_eo_next = LAMP_G;
                paso_next   = 1'b1;
                vel_next    = 2'b01;
            end
            EO_PARPADEO: begin
                sem_eo_next = tmr_reg[0] ? LAMP_OFF : LAMP_G;
                paso_next   = 1'b1;
                vel_next    = 2'b10;
            end
            EO_AMARILLO: begin
                sem_eo_next = LAMP_Y;
                vel_next    = 2'b11;
            end
            NS_VERDE:    sem_ns_next = LAMP_G;
            NS_PARPADEO: sem_ns_next = tmr_reg[0] ? LAMP_OFF : LAMP_G;
            NS_AMARILLO: sem_ns_next = LAMP_Y;
            NOCHE_PARP: begin
                sem_eo_next = tmr_reg[0] ? LAMP_OFF : LAMP_Y;
                sem_ns_next = tmr_reg[0] ? LAMP_R   : LAMP_OFF;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc_reg      <= '0;
            tick_reg       <= 1'b0;
            noche_sync_reg <= 2'b00;
            boton_sync_reg <= 2'b00;
            boton_prev_reg <= 1'b0;
            state_reg      <= ROJO_2;
            tmr_reg        <= 5'd0;
            pend_reg       <= 1'b0;
            sem_eo_reg     <= LAMP_R;
            sem_ns_reg     <= LAMP_R;
            paso_reg       <= 1'b0;
            vel_reg        <= 2'b00;
            fase_reg       <= 4'd7;
        end else begin
            presc_reg      <= presc_next;
            tick_reg       <= (presc_next == PW'(TICK_DIV - 1));
            noche_sync_reg <= {noche_sync_reg[0], bus.NOCHE};
            boton_sync_reg <= {boton_sync_reg[0], bus.BOTON_NS};
            boton_prev_reg <= boton_sync_reg[1];
            state_reg      <= state_next;
            tmr_reg        <= tmr_next;
            pend_reg       <= pend_next;
            sem_eo_reg     <= sem_eo_next;
            sem_ns_reg     <= sem_ns_next;
            paso_reg       <= paso_next;
            vel_reg        <= vel_next;
            fase_reg       <= state_reg;
        end
    end

    assign bus.SEMAFORO_EO  = sem_eo_reg;
    assign bus.SEMAFORO_NS  = sem_ns_reg;
    assign bus.PASO_NS      = paso_reg;
    assign bus.VELOCIDAD_NS = vel_reg;
    assign bus.FASE         = fase_reg;
    assign bus.TICK         = tick_reg;

endmodule

// File: tb/tb_semaforo_scheduler.sv
// ----------------------------------------------------------------------------
// tb_semaforo_scheduler
//   Scoreboard bench: the expected per-tick lamp/phase snapshot sequence is
//   queued as the scenario is planned; a monitor samples the outputs in every
//   TICK cycle and compares against the head of the queue.
// ----------------------------------------------------------------------------
module tb_semaforo_scheduler;

    localparam int TICK_DIV = 4;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    semaforo_scheduler_if bus();

    semaforo_scheduler #(.TICK_DIV(TICK_DIV)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    // snapshot = {FASE[3:0], EO[2:0], NS[2:0], PASO, VEL[1:0]}
    logic [12:0] exp_q[$];
    int plan_len   = 0;
    int sample_idx = 0;

    int press1, press2, hold_s, press_eo;
    int noche_on, noche_off, ped2, noche_off2, reset_at;

    task automatic check_val(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [12:0] expect_for(input logic [3:0] f, input int t);
        logic [2:0] eo;
        logic [2:0] ns;
        logic       paso;
        logic [1:0] vel;
        logic       odd;
        odd  = (t % 2) == 1;
        eo   = 3'b001;
        ns   = 3'b001;
        paso = 1'b0;
        vel  = 2'b00;
        case (f)
            4'd0: begin eo = 3'b100; paso = 1'b1; vel = 2'b01; end
            4'd1: begin eo = odd ? 3'b000 : 3'b100; paso = 1'b1; vel = 2'b10; end
            4'd2: begin eo = 3'b010; vel = 2'b11; end
            4'd4: ns = 3'b100;
            4'd5: ns = odd ? 3'b000 : 3'b100;
            4'd6: ns = 3'b010;
            4'd8: begin
                eo = odd ? 3'b000 : 3'b010;
                ns = odd ? 3'b001 : 3'b000;
            end
            default: ;
        endcase
        return {f, eo, ns, paso, vel};
    endfunction

    task automatic push_phase(input logic [3:0] f, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(expect_for(f, i));
        plan_len += n;
    endtask

    task automatic push_eo_half();
        push_phase(4'd0, 8);
        push_phase(4'd1, 4);
        push_phase(4'd2, 3);
        push_phase(4'd3, 1);
    endtask

    task automatic push_ns_tail();
        push_phase(4'd5, 4);
        push_phase(4'd6, 3);
        push_phase(4'd7, 1);
    endtask

    // Returns just after the negedge of the TICK cycle of sample n.
    task automatic wait_sample(input int n);
        int budget;
        budget = 0;
        while (sample_idx < n && budget < 2000) begin
            @(negedge CLK);
            #1;
            budget++;
        end
        if (sample_idx != n)
            check_val("wait_sample", 16'(sample_idx), 16'(n));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_fase"}, 16'(bus.FASE), 16'd7);
        check_val({tag, "_eo"},   16'(bus.SEMAFORO_EO), 16'b001);
        check_val({tag, "_ns"},   16'(bus.SEMAFORO_NS), 16'b001);
        check_val({tag, "_paso"}, 16'(bus.PASO_NS), 16'd0);
        check_val({tag, "_vel"},  16'(bus.VELOCIDAD_NS), 16'd0);
        check_val({tag, "_tick"}, 16'(bus.TICK), 16'd0);
    endtask

    // Monitor: one comparison per tick plus the tick spacing.
    initial begin : monitor
        int gap;
        bit tick_seen;
        logic [12:0] e;
        logic [12:0] obs;
        gap = 0;
        tick_seen = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                tick_seen = 1'b0;
                gap = 0;
            end else begin
                gap++;
                if (bus.TICK) begin
                    if (tick_seen)
                        check_val("tick_gap", 16'(gap), 16'(TICK_DIV));
                    tick_seen = 1'b1;
                    gap = 0;
                    sample_idx++;
                    if (exp_q.size() > 0) begin
                        e   = exp_q.pop_front();
                        obs = {bus.FASE, bus.SEMAFORO_EO, bus.SEMAFORO_NS,
                               bus.PASO_NS, bus.VELOCIDAD_NS};
                        check_val($sformatf("tick%0d", sample_idx), 16'(obs), 16'(e));
                        $display("tick %0d fase=%0d eo=%b ns=%b paso=%b vel=%b",
                                 sample_idx, bus.FASE, bus.SEMAFORO_EO,
                                 bus.SEMAFORO_NS, bus.PASO_NS, bus.VELOCIDAD_NS);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        bus.NOCHE    = 1'b0;
        bus.BOTON_NS = 1'b0;

        // Plan: sample k shows the phase in force after k-1 ticks.
        push_phase(4'd7, 1);
        push_eo_half(); push_phase(4'd4, 8); push_ns_tail();            // plain ring
        push_eo_half(); press1 = plan_len + 1;                          // call at TMR=1
        push_phase(4'd4, 4); push_ns_tail();
        push_eo_half(); press2 = plan_len + 6;                          // call at TMR=6
        push_phase(4'd4, 7); push_ns_tail();
        push_eo_half(); push_phase(4'd4, 8); hold_s = plan_len + 2;     // held 20 ticks
        push_ns_tail();
        push_eo_half(); push_phase(4'd4, 8); push_ns_tail();            // no second call
        press_eo = plan_len + 3;                                        // ignored in EO green
        push_eo_half(); push_phase(4'd4, 8); push_ns_tail();
        noche_on = plan_len + 4;                                        // night mid EO green
        push_eo_half(); noche_off = plan_len + 5;
        push_phase(4'd8, 6); push_phase(4'd7, 1);
        push_eo_half(); push_phase(4'd4, 8); push_phase(4'd5, 4);       // night + call at ROJO_2
        ped2 = plan_len + 1;
        push_phase(4'd6, 3); push_phase(4'd7, 1);
        noche_off2 = plan_len + 3;
        push_phase(4'd8, 4); push_phase(4'd7, 1);
        push_eo_half(); push_phase(4'd4, 8); push_phase(4'd5, 4);       // full NS green after night
        push_phase(4'd6, 1);
        reset_at = plan_len;                                            // reset mid NS_AMARILLO

        repeat (3) @(negedge CLK);
        check_reset_outputs("rst_init");
        #1 RST_N = 1'b1;

        wait_sample(press1);     bus.BOTON_NS = 1'b1;
        wait_sample(press1 + 1); bus.BOTON_NS = 1'b0;
        wait_sample(press2);     bus.BOTON_NS = 1'b1;
        wait_sample(press2 + 1); bus.BOTON_NS = 1'b0;
        wait_sample(hold_s);      bus.BOTON_NS = 1'b1;
        wait_sample(hold_s + 20); bus.BOTON_NS = 1'b0;
        wait_sample(press_eo);     bus.BOTON_NS = 1'b1;
        wait_sample(press_eo + 1); bus.BOTON_NS = 1'b0;
        wait_sample(noche_on);  bus.NOCHE = 1'b1;
        wait_sample(noche_off); bus.NOCHE = 1'b0;
        wait_sample(ped2);      bus.BOTON_NS = 1'b1; bus.NOCHE = 1'b1;
        wait_sample(ped2 + 1);  bus.BOTON_NS = 1'b0;
        wait_sample(noche_off2); bus.NOCHE = 1'b0;

        // Asynchronous reset between clock edges.
        wait_sample(reset_at);
        check_val("plan_consumed", 16'(exp_q.size()), 16'd0);
        #2 RST_N = 1'b0;
        #1 check_reset_outputs("rst_async");

        push_phase(4'd7, 1);
        push_phase(4'd0, 8);
        push_phase(4'd1, 2);
        repeat (2) @(negedge CLK);
        #1 RST_N = 1'b1;

        // The release cycle holds prescaler 0, so the pulse occupies the
        // TICK_DIV-th cycle, i.e. it is seen after TICK_DIV-1 rising edges.
        n = 0;
        while (n < 20) begin
            @(posedge CLK);
            n++;
            #1;
            if (bus.TICK) break;
        end
        check_val("first_tick", 16'(n), 16'(TICK_DIV - 1));

        n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            @(negedge CLK);
            n++;
        end
        check_val("drain", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
